// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: pipelined carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_SATURATE_EN to add the sat input and an extra clamp stage (latency L+1).
module pipelined_cla_addsub #(
    parameter int WIDTH            = 32,
    parameter int GROUP            = 4,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_SATURATE_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = GROUP * GROUPS_PER_STAGE;
    localparam int L  = WIDTH / SW;

    // Returns {carry into slice MSB, slice carry-out, slice sum}.
    function automatic logic [SW+1:0] slice_add(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                input logic ci);
        logic [SW:0]   c;
        logic [SW-1:0] p, g;
        logic          gg, pp;
        p    = x ^ y;
        g    = x & y;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            for (int i = 0; i < GROUP; i++) begin
                gg = 1'b0;
                pp = 1'b1;
                for (int t = 0; t <= i; t++) begin
                    gg = g[j*GROUP+t] | (p[j*GROUP+t] & gg);
                    pp = pp & p[j*GROUP+t];
                end
                c[j*GROUP+i+1] = gg | (pp & c[j*GROUP]);
            end
        end
        return {c[SW-1], c[SW], p ^ c[SW-1:0]};
    endfunction

    logic             adv;
    logic [L-1:0]     v_q, v_d, c_q, c_d;
    logic [WIDTH-1:0] a_q [L], a_d [L];
    logic [WIDTH-1:0] b_q [L], b_d [L];
    logic [WIDTH-1:0] sum_q [L], sum_d [L];
    logic [SW+1:0]    r [L];
    logic [WIDTH-1:0] fin;
    logic             o_v_q, o_v_d, o_c_q, o_c_d, o_ovf_q, o_ovf_d, o_z_q, o_z_d;
    logic [WIDTH-1:0] o_s_q, o_s_d;
`ifdef CLA_SATURATE_EN
    logic [L-1:0]     sat_q, sat_d;
    logic             o_sat_q, o_sat_d, o_neg_q, o_neg_d;
    logic             x_v_q, x_v_d, x_c_q, x_c_d, x_ovf_q, x_ovf_d, x_z_q, x_z_d;
    logic [WIDTH-1:0] x_s_q, x_s_d;
`endif

    // Stage k holds operands with slices k.. still to add and the finished sum slices below k.
    always_comb begin
        adv      = !out_valid | out_ready;
        in_ready = adv;
        v_d[0]   = in_valid;
        a_d[0]   = a;
        b_d[0]   = sub ? ~b : b;
        c_d[0]   = sub ? !cin : cin;
        sum_d[0] = '0;
        for (int k = 0; k < L; k++) begin
            r[k] = slice_add(a_q[k][k*SW +: SW], b_q[k][k*SW +: SW], c_q[k]);
        end
        for (int k = 1; k < L; k++) begin
            v_d[k]   = v_q[k-1];
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            c_d[k]   = r[k-1][SW];
            sum_d[k] = sum_q[k-1];
            sum_d[k][(k-1)*SW +: SW] = r[k-1][SW-1:0];
        end
        fin = sum_q[L-1];
        fin[(L-1)*SW +: SW] = r[L-1][SW-1:0];
        o_v_d   = v_q[L-1];
        o_s_d   = fin;
        o_c_d   = r[L-1][SW];
        o_ovf_d = r[L-1][SW] ^ r[L-1][SW+1];
        o_z_d   = fin == '0;
`ifdef CLA_SATURATE_EN
        sat_d[0] = sat;
        for (int k = 1; k < L; k++) begin
            sat_d[k] = sat_q[k-1];
        end
        o_sat_d = sat_q[L-1];
        o_neg_d = a_q[L-1][WIDTH-1];
        x_v_d   = o_v_q;
        x_c_d   = o_c_q;
        x_ovf_d = o_ovf_q;
        x_s_d   = (o_sat_q && o_ovf_q) ? (o_neg_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}}) : o_s_q;
        x_z_d   = x_s_d == '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q     <= '0;
            c_q     <= '0;
            o_v_q   <= 1'b0;
            o_s_q   <= '0;
            o_c_q   <= 1'b0;
            o_ovf_q <= 1'b0;
            o_z_q   <= 1'b0;
            for (int k = 0; k < L; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
`ifdef CLA_SATURATE_EN
            sat_q   <= '0;
            o_sat_q <= 1'b0;
            o_neg_q <= 1'b0;
            x_v_q   <= 1'b0;
            x_s_q   <= '0;
            x_c_q   <= 1'b0;
            x_ovf_q <= 1'b0;
            x_z_q   <= 1'b0;
`endif
        end else if (adv) begin
            v_q     <= v_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            o_v_q   <= o_v_d;
            o_s_q   <= o_s_d;
            o_c_q   <= o_c_d;
            o_ovf_q <= o_ovf_d;
            o_z_q   <= o_z_d;
`ifdef CLA_SATURATE_EN
            sat_q   <= sat_d;
            o_sat_q <= o_sat_d;
            o_neg_q <= o_neg_d;
            x_v_q   <= x_v_d;
            x_s_q   <= x_s_d;
            x_c_q   <= x_c_d;
            x_ovf_q <= x_ovf_d;
            x_z_q   <= x_z_d;
`endif
        end
    end

`ifdef CLA_SATURATE_EN
    assign out_valid = x_v_q;
    assign s         = x_s_q;
    assign cout      = x_c_q;
    assign ovf       = x_ovf_q;
    assign zero      = x_z_q;
`else
    assign out_valid = o_v_q;
    assign s         = o_s_q;
    assign cout      = o_c_q;
    assign ovf       = o_ovf_q;
    assign zero      = o_z_q;
`endif
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: scoreboard bench for the pipelined CLA adder/subtractor.
module tb_pipelined_cla_addsub;
`ifdef CLA_SATURATE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif
    typedef struct packed {logic [31:0] s; logic c; logic o; logic z;} res_t;

    logic        clk = 0, rst = 1, in_valid = 0, cin = 0, sub = 0, out_ready = 1, sat = 0;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] a = 0, b = 0, s;
    res_t        q[$];
    res_t        e, held;
    logic        hold_v = 0;
    int          checks = 0, errors = 0;

    // Directed vectors: a, b, cin, sub, expected s, cout, ovf, zero (hand-computed).
    logic [31:0] va [10] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'd7,
                             32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'h00001234, 32'h80000000};
    logic [31:0] vb [10] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'd7, 32'd5,
                             32'h00000001, 32'h11111111, 32'hFFFFFFFF, 32'h00001234, 32'h80000000};
    logic        vc [10] = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    logic        vs [10] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 0};
    res_t        vx [10] = '{'{32'h00010000, 0, 0, 0}, '{32'h00000000, 1, 0, 1},
                             '{32'h80000000, 0, 1, 0}, '{32'hFFFFFFFE, 0, 0, 0},
                             '{32'h00000001, 1, 0, 0}, '{32'h7FFFFFFF, 1, 1, 0},
                             '{32'h2345678A, 0, 0, 0}, '{32'hFFFFFFFF, 1, 0, 0},
                             '{32'h00000000, 1, 0, 1}, '{32'h00000000, 1, 1, 1}};

    always #5 clk = ~clk;

    pipelined_cla_addsub dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub),
`ifdef CLA_SATURATE_EN
        .sat(sat),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb,
                                   input logic tc, input logic ts);
        logic [32:0] t;
        logic [31:0] lo, bx;
        logic        ci;
        bx = ts ? ~tb : tb;
        ci = ts ? !tc : tc;
        t  = {1'b0, ta} + {1'b0, bx} + 33'(ci);
        lo = {1'b0, ta[30:0]} + {1'b0, bx[30:0]} + 32'(ci);
        return '{t[31:0], t[32], t[32] ^ lo[31], t[31:0] == 0};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && !out_ready) begin
                if (hold_v) begin
                    chk("hold_s", s, held.s);
                    chk("hold_flags", {cout, ovf, zero}, {held.c, held.o, held.z});
                end
                held   = '{s, cout, ovf, zero};
                hold_v = 1;
            end else hold_v = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got s=%h with nothing expected", s);
                end else begin
                    e = q.pop_front();
                    chk("s", s, e.s);
                    chk("flags_c_o_z", {cout, ovf, zero}, {e.c, e.o, e.z});
                end
            end
        end
    end

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                        input logic ts, input res_t x);
        int n = 0;
        in_valid = 1; a = ta; b = tb; cin = tc; sub = ts;
        do begin @(negedge clk); n++; end while (!in_ready && n < 50);
        @(posedge clk);
        q.push_back(x);
        #1 in_valid = 0;
    endtask

    task automatic latency_op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                              input logic ts, input res_t x);
        int n = 0;
        in_valid = 1; a = ta; b = tb; cin = tc; sub = ts;
        @(posedge clk);
        q.push_back(x);
        #1 in_valid = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("latency", n, LAT);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(posedge clk); n++; end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] sa [10], sb [10];
        logic        sc [10], ss [10];
        int          cyc, idx, cnt;
        logic        acc;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_flags", {cout, ovf, zero}, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        chk("in_ready_after_rst", in_ready, 1);
        latency_op(va[0], vb[0], vc[0], vs[0], vx[0]);
        drain();
        for (int i = 1; i < 10; i++) send(va[i], vb[i], vc[i], vs[i], vx[i]);
        drain();
        for (int i = 0; i < 10; i++) begin
            sa[i] = $urandom; sb[i] = $urandom; sc[i] = 1'($urandom); ss[i] = 1'($urandom);
        end
        sa[3] = 32'h7FFFFFF0; sb[3] = 32'h00000020; ss[3] = 0;
        cyc = 0; idx = 0;
        while (idx < 10 && cyc < 200) begin
            out_ready = !(cyc inside {6, 7, 8});
            in_valid = 1; a = sa[idx]; b = sb[idx]; cin = sc[idx]; sub = ss[idx];
            @(negedge clk);
            if (cyc inside {6, 7, 8}) chk("stall_in_ready", in_ready, 0);
            acc = in_ready;
            @(posedge clk);
            if (acc) begin q.push_back(model(sa[idx], sb[idx], sc[idx], ss[idx])); idx++; end
            #1 cyc++;
        end
        in_valid = 0; out_ready = 1;
        chk("stream_issued", idx, 10);
        drain();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; a = 32'(i + 9); b = 32'h00001000; cin = 0; sub = 0;
            @(posedge clk);
        end
        #2 rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        in_valid = 0;
        @(posedge clk); #1 rst = 0;
        cnt = 0;
        repeat (8) begin @(posedge clk); #1 if (out_valid) cnt++; end
        chk("no_stale_after_rst", cnt, 0);
        latency_op(32'h00000003, 32'h00000004, 0, 0, '{32'h00000007, 0, 0, 0});
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
